// File: rtl/switch_debounce_encoder_if.sv
// Raw switch inputs and cleaned level/event outputs of the switch front end.
// master drives the raw switches; slave is the debounce/encoder block.
interface switch_debounce_encoder_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       o_Switch_1;
  logic       o_Switch_2;
  logic       o_Switch_3;
  logic       o_Switch_4;
  logic       o_Button_DV;
  logic [1:0] o_Button_ID;
  logic       o_Chord;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4,
    input  o_Button_DV, o_Button_ID, o_Chord
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4,
    output o_Button_DV, o_Button_ID, o_Chord
  );
endinterface

// File: rtl/switch_debounce_encoder.sv
// Sync + debounce 4 switches (level latency DEBOUNCE_CLKS+2), one-cycle release events, no backpressure.
// SWITCH_DEBOUNCE_CHORD_EN adds the switch 1+2 chord output and suppresses its release events.
module switch_debounce_encoder #(
  parameter int DEBOUNCE_CLKS = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  switch_debounce_encoder_if.slave sw
);

  localparam int CW = (DEBOUNCE_CLKS > 2) ? $clog2(DEBOUNCE_CLKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CLKS - 1);

  logic [3:0]         raw;
  logic [3:0]         meta_q, sync_q;
  logic [3:0]         deb_q, deb_d;
  logic [3:0]         lvl_q;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         pend_q, pend_d;
  logic [3:0]         fall, clr, rel_mask;
  logic               dv_q, dv_d;
  logic [1:0]         id_q, id_d;

  assign raw = {sw.i_Switch_4, sw.i_Switch_3, sw.i_Switch_2, sw.i_Switch_1};

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int n = 0; n < 4; n++) begin
      if (sync_q[n] != deb_q[n]) begin
        if (cnt_q[n] == CNT_MAX) begin
          deb_d[n] = sync_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  // lvl_q is the previous debounced level, so a release is seen one cycle after it lands
  assign fall = lvl_q & ~deb_q & rel_mask;

  always_comb begin
    dv_d = 1'b0;
    id_d = 2'd0;
    clr  = 4'b0000;
    if (pend_q != 4'b0000) begin
      dv_d = 1'b1;
      for (int n = 3; n >= 0; n--) begin
        if (pend_q[n]) id_d = 2'(n);
      end
      clr = 4'b0001 << id_d;
    end
    pend_d = (pend_q & ~clr) | fall;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      meta_q <= '0;
      sync_q <= '0;
      deb_q  <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      dv_q   <= 1'b0;
      id_q   <= 2'd0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      lvl_q  <= deb_q;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      dv_q   <= dv_d;
      id_q   <= id_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_CHORD_EN
  logic latch_q, latch_d;
  logic chord_q;

  always_comb begin
    latch_d = latch_q;
    if (deb_q[0] & deb_q[1]) begin
      latch_d = 1'b1;
    end else if (~deb_q[0] & ~deb_q[1]) begin
      latch_d = 1'b0;
    end
  end

  // Latch still reads set on the cycle both releases are detected, so the chord stays silent
  assign rel_mask = latch_q ? 4'b1100 : 4'b1111;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      latch_q <= 1'b0;
      chord_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
      chord_q <= deb_q[0] & deb_q[1];
    end
  end

  assign sw.o_Chord = chord_q;
`else
  assign rel_mask   = 4'b1111;
  assign sw.o_Chord = 1'b0;
`endif

  assign sw.o_Switch_1  = lvl_q[0];
  assign sw.o_Switch_2  = lvl_q[1];
  assign sw.o_Switch_3  = lvl_q[2];
  assign sw.o_Switch_4  = lvl_q[3];
  assign sw.o_Button_DV = dv_q;
  assign sw.o_Button_ID = id_q;

endmodule

// File: tb/tb_switch_debounce_encoder.sv
// Directed bench for switch_debounce_encoder with DEBOUNCE_CLKS=4; release events checked by a scoreboard.
module tb_switch_debounce_encoder;

`ifdef SWITCH_DEBOUNCE_CHORD_EN
  localparam int CHORD = 1;
`else
  localparam int CHORD = 0;
`endif

  logic clk = 1'b0;
  logic rst_l;
  int   cyc = 0;
  int   nchk = 0;
  int   errors = 0;

  typedef struct {
    int id;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  switch_debounce_encoder_if bus();

  switch_debounce_encoder #(.DEBOUNCE_CLKS(4)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .sw      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every DV pulse must match the next expected event, id and cycle
  always @(negedge clk) begin
    if (bus.o_Button_DV === 1'b1) begin
      nchk++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got id=%0d at cycle %0d, required no event", bus.o_Button_ID, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (int'(bus.o_Button_ID) != e.id || cyc != e.cyc) begin
          errors++;
          $display("FAIL event: got id=%0d at cycle %0d, required id=%0d at cycle %0d",
                   bus.o_Button_ID, cyc, e.id, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int id, input int at);
    ev_t e;
    e.id  = id;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  initial begin
    int base;
    bit seen;
    rst_l = 1'b0;
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    bus.i_Switch_3 = 1'b0;
    bus.i_Switch_4 = 1'b0;
    step(3);
    check("rst_sw1", int'(bus.o_Switch_1), 0);
    check("rst_sw4", int'(bus.o_Switch_4), 0);
    check("rst_dv", int'(bus.o_Button_DV), 0);
    check("rst_id", int'(bus.o_Button_ID), 0);
    check("rst_chord", int'(bus.o_Chord), 0);
    rst_l = 1'b1;
    step(2);

    // 1: clean press/release of switch 3
    bus.i_Switch_3 = 1'b1;
    step(6);
    check("s1_rise_not_early", int'(bus.o_Switch_3), 0);
    step(1);
    check("s1_rise_at_6", int'(bus.o_Switch_3), 1);
    step(4);
    bus.i_Switch_3 = 1'b0;
    base = cyc;
    expect_ev(2, base + 8);
    step(6);
    check("s1_fall_not_early", int'(bus.o_Switch_3), 1);
    step(1);
    check("s1_fall_at_6", int'(bus.o_Switch_3), 0);
    step(6);

    // 2: bounce shorter than the debounce window never changes the level
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) bus.i_Switch_1 = ~bus.i_Switch_1;
      step(1);
      if (bus.o_Switch_1) seen = 1'b1;
    end
    bus.i_Switch_1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.o_Switch_1) seen = 1'b1;
    end
    check("s2_bounce_level_high_seen", int'(seen), 0);

    // 3: simultaneous release of 2,3,4 queues three events lowest ID first
    bus.i_Switch_2 = 1'b1;
    bus.i_Switch_3 = 1'b1;
    bus.i_Switch_4 = 1'b1;
    step(10);
    check("s3_levels_held", int'({bus.o_Switch_4, bus.o_Switch_3, bus.o_Switch_2, bus.o_Switch_1}), 14);
    bus.i_Switch_2 = 1'b0;
    bus.i_Switch_3 = 1'b0;
    bus.i_Switch_4 = 1'b0;
    base = cyc;
    expect_ev(1, base + 8);
    expect_ev(2, base + 9);
    expect_ev(3, base + 10);
    step(14);
    check("s3_levels_released", int'({bus.o_Switch_4, bus.o_Switch_3, bus.o_Switch_2, bus.o_Switch_1}), 0);

    // 4: reset while switch 4 is high and switch 3 is mid-count
    bus.i_Switch_4 = 1'b1;
    step(10);
    check("s4_sw4_high", int'(bus.o_Switch_4), 1);
    bus.i_Switch_3 = 1'b1;
    step(3);
    rst_l = 1'b0;
    step(1);
    check("s4_rst_sw4", int'(bus.o_Switch_4), 0);
    check("s4_rst_sw3", int'(bus.o_Switch_3), 0);
    check("s4_rst_dv", int'(bus.o_Button_DV), 0);
    rst_l = 1'b1;
    step(6);
    check("s4_redeb_not_early", int'(bus.o_Switch_4), 0);
    step(1);
    check("s4_redeb_sw4", int'(bus.o_Switch_4), 1);
    check("s4_redeb_sw3", int'(bus.o_Switch_3), 1);
    step(3);
    bus.i_Switch_3 = 1'b0;
    bus.i_Switch_4 = 1'b0;
    base = cyc;
    expect_ev(2, base + 8);
    expect_ev(3, base + 9);
    step(12);

    // 5/6: switches 1+2 held together then released together
    bus.i_Switch_1 = 1'b1;
    bus.i_Switch_2 = 1'b1;
    step(6);
    check("s5_chord_not_early", int'(bus.o_Chord), 0);
    step(1);
    check("s5_chord_held", int'(bus.o_Chord), CHORD);
    check("s5_sw12_levels", int'({bus.o_Switch_2, bus.o_Switch_1}), 3);
    step(3);
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    base = cyc;
    if (CHORD == 0) begin
      expect_ev(0, base + 8);
      expect_ev(1, base + 9);
    end
    step(12);
    check("s5_chord_released", int'(bus.o_Chord), 0);
    bus.i_Switch_1 = 1'b1;
    step(10);
    check("s5_lone_no_chord", int'(bus.o_Chord), 0);
    bus.i_Switch_1 = 1'b0;
    base = cyc;
    expect_ev(0, base + 8);
    step(12);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule

// File: doc/switch_debounce_encoder.md
Name: switch_debounce_encoder

Overview:
Front-end stage that feeds the memory-game state machine. It synchronises and debounces the four raw board switches, then turns switch releases into single-cycle button events carrying a 2-bit button ID. The game logic consumes clean levels (LED echo, reset chord) and one event per release, and never sees raw switch bounce.

Parameters:
DEBOUNCE_CLKS, 250000, consecutive synchronised-stable clocks required before a debounced level changes (10 ms at 25 MHz); minimum 2.

Ports:
i_Clk  input  1  system clock; single clock domain.
i_Rst_L  input  1  synchronous reset, active-low.
i_Switch_1  input  1  raw switch 1, asynchronous, bouncy.
i_Switch_2  input  1  raw switch 2.
i_Switch_3  input  1  raw switch 3.
i_Switch_4  input  1  raw switch 4.
o_Switch_1  output  1  debounced level, switch 1.
o_Switch_2  output  1  debounced level, switch 2.
o_Switch_3  output  1  debounced level, switch 3.
o_Switch_4  output  1  debounced level, switch 4.
o_Button_DV  output  1  one-cycle pulse; one switch release event.
o_Button_ID  output  2  ID of the released switch (0..3 = switch 1..4); valid only while o_Button_DV = 1.
o_Chord  output  1  switches 1 and 2 both held (debounced); driven only when SWITCH_DEBOUNCE_CHORD_EN is defined.

Behaviour:
- Reset: i_Rst_L sampled low at a rising edge of i_Clk. All of the following clear to 0: synchroniser flops, debounced levels, counters, pending mask, chord latch, and every output. Reset mid-count discards the partial count. Reset mid-queue discards pending events. No event is generated when leaving reset.
- Synchroniser: two flops per channel. The synchronised value is s[n].
- Debounce counter: one per channel, width $clog2(DEBOUNCE_CLKS).
  - s[n] == d[n]: counter <= 0.
  - s[n] != d[n] and counter < DEBOUNCE_CLKS-1: counter increments.
  - s[n] != d[n] and counter == DEBOUNCE_CLKS-1: d[n] <= s[n], counter <= 0.
  - A glitch shorter than DEBOUNCE_CLKS synchronised cycles restarts the count and never changes d.
- Latency: a clean raw edge reaches o_Switch_n exactly DEBOUNCE_CLKS+2 clocks after the first i_Clk edge that samples it. o_Switch_n = d[n], registered.
- Release detect: a falling edge of d[n] (1 -> 0) sets pending[n]. Press edges produce no event.
- Event encoder:
  - Each cycle with pending != 0: o_Button_DV <= 1, o_Button_ID <= index of the lowest set pending bit, and that bit clears.
  - pending == 0: o_Button_DV <= 0, o_Button_ID <= 0.
  - Simultaneous releases are queued and emitted on consecutive cycles, lowest ID first; none are lost.
  - If pending[n] is being set and cleared in the same cycle, set wins.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro: SWITCH_DEBOUNCE_CHORD_EN.
- Defined:
  - o_Chord <= d[0] & d[1], registered.
  - A chord latch sets when d[0] & d[1] = 1 and clears when d[0] = d[1] = 0.
  - While the latch is set, falling edges of d[0] and d[1] do not set pending. The reset chord therefore never produces button events.
  - Switches 3 and 4 are unaffected.
- Not defined: o_Chord is tied 0, no latch is built, and every release of every switch produces an event.

Test Plan:
1. DEBOUNCE_CLKS=4; hold i_Switch_3 = 1 from cycle 0 -> o_Switch_3 rises at cycle 6. Release -> o_Switch_3 falls 6 clocks later; o_Button_DV = 1 for exactly one cycle, 1 cycle after the fall, with o_Button_ID = 2.
2. DEBOUNCE_CLKS=4; i_Switch_1 toggles every 2 clocks for 20 clocks, then settles at 0 -> o_Switch_1 stays 0 and no o_Button_DV pulse occurs.
3. Press switches 2, 3 and 4; release all three on the same cycle -> three DV pulses on consecutive cycles with IDs 1, 2, 3.
4. Drive i_Rst_L = 0 for one cycle while switch 4 is debounced high and a count is in progress -> all outputs 0 next cycle. Switch 4 re-debounces after DEBOUNCE_CLKS+2 clocks, and no event is generated.
5. SWITCH_DEBOUNCE_CHORD_EN defined: hold switches 1 and 2, then release both -> o_Chord = 1 while both are held and no DV pulse follows. A later lone press/release of switch 1 -> one pulse with ID 0.
6. SWITCH_DEBOUNCE_CHORD_EN undefined: same stimulus as scenario 5 -> o_Chord stays 0, and pulses with ID 0 then ID 1 follow on consecutive cycles.
